// File: rtl/pc_gen_pkg.sv
// Shared types and defaults for the fetch-stage PC generator.
// The output struct is sized for the default widths, which are the widest the top supports.
package pc_gen_pkg;

    localparam int DEF_XLEN    = 64;
    localparam int DEF_ILEN    = 32;
    localparam int DEF_PC_STEP = 4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] instr;
    } fetch_out_t;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-bus and decode-side handshake bundle for pc_gen.
// master = fetch unit side, slave = ibus/decode environment side.
interface pc_gen_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) ();

    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            ireq_ready;
    logic            iresp_valid;
    logic [ILEN-1:0] iresp_data;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;
    logic            out_ready;

    modport master (
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        input  ireq_ready, iresp_valid, iresp_data, out_ready
    );

    modport slave (
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
        output ireq_ready, iresp_valid, iresp_data, out_ready
    );

endinterface

// File: rtl/pc_gen_redir_arb.sv
// Fixed-priority redirect arbiter: lowest-index valid source wins, and its
// target is aligned down to a PC_STEP boundary.
module pc_gen_redir_arb #(
    parameter int XLEN      = 64,
    parameter int NUM_REDIR = 2,
    parameter int PC_STEP   = 4
) (
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
    output logic                      sel_valid,
    output logic [XLEN-1:0]           sel_pc
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(PC_STEP) - XLEN'(1));

    logic [XLEN-1:0] raw_pc;

    // Scan from the lowest priority upward so the highest-priority hit is written last.
    always_comb begin
        sel_valid = 1'b0;
        raw_pc    = '0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (redir_valid[i]) begin
                sel_valid = 1'b1;
                raw_pc    = redir_pc[i*XLEN +: XLEN];
            end
        end
        sel_pc = raw_pc & ALIGN_MASK;
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: one outstanding ibus request at a time, redirect arbitration,
// kill of in-flight responses, and a valid/ready hand-off of {pc, instr} to decode.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int              XLEN      = DEF_XLEN,
    parameter int              ILEN      = DEF_ILEN,
    parameter int              NUM_REDIR = 2,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h8000_0000),
    parameter int              PC_STEP   = DEF_PC_STEP
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REDIR-1:0]      redir_valid,
    input  logic [NUM_REDIR*XLEN-1:0] redir_pc,
    pc_gen_if.master                  bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            pend_q, pend_d;
    fetch_out_t      out_q, out_d;

    logic            redir_hit;
    logic [XLEN-1:0] redir_target;

    pc_gen_redir_arb #(
        .XLEN      (XLEN),
        .NUM_REDIR (NUM_REDIR),
        .PC_STEP   (PC_STEP)
    ) u_redir_arb (
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .sel_valid   (redir_hit),
        .sel_pc      (redir_target)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
            pend_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
        end
    end

    // A redirect always wins the PC; kill_q marks an accepted request whose data must be dropped.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        pend_d  = pend_q;
        out_d   = out_q;

        case (state_q)
            REQ: begin
                if (bus.ireq_ready) begin
                    state_d = WAIT;
                    kill_d  = redir_hit;
                end
            end
            WAIT: begin
                if (bus.iresp_valid) begin
                    state_d = REQ;
                    kill_d  = 1'b0;
                    if (!kill_q && !redir_hit) begin
                        out_d.pc    = DEF_XLEN'(pc_q);
                        out_d.instr = DEF_ILEN'(bus.iresp_data);
                        pend_d      = 1'b1;
                        pc_d        = pc_q + XLEN'(PC_STEP);
                        state_d     = HOLD;
                    end
                end else if (redir_hit) begin
                    kill_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir_hit || bus.out_ready) begin
                    pend_d  = 1'b0;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (redir_hit) begin
            pc_d = redir_target;
        end
    end

    assign bus.ireq_valid = resetn && (state_q == REQ);
    assign bus.ireq_addr  = pc_q;
    assign bus.out_valid  = pend_q;
    assign bus.out_pc     = XLEN'(out_q.pc);
    assign bus.out_instr  = ILEN'(out_q.instr);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a scripted/auto ibus responder, a scoreboard queue of
// expected decode hand-offs, and a monitor that pops it on every handshake.
module tb_pc_gen;
    import pc_gen_pkg::*;

    logic        clk;
    logic        resetn;
    logic [1:0]  redir_valid;
    logic [63:0] redir_pc0;
    logic [63:0] redir_pc1;

    pc_gen_if #(.XLEN(64), .ILEN(32)) bus ();

    pc_gen dut (
        .clk         (clk),
        .resetn      (resetn),
        .redir_valid (redir_valid),
        .redir_pc    ({redir_pc1, redir_pc0}),
        .bus         (bus)
    );

    int n_compared = 0;
    int n_mismatch = 0;

    fetch_out_t sb_q[$];

    logic        resp_en;
    logic        auto_valid;
    logic [31:0] auto_data;
    logic        man_valid;
    logic [31:0] man_data;

    assign bus.iresp_valid = auto_valid | man_valid;
    assign bus.iresp_data  = man_valid ? man_data : auto_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] addr);
        return addr[31:0] ^ 32'h1357_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] rv, input logic [63:0] p0,
                                 input logic [63:0] p1, input logic ireq_rdy,
                                 input logic out_rdy);
        redir_valid    = rv;
        redir_pc0      = p0;
        redir_pc1      = p1;
        bus.ireq_ready = ireq_rdy;
        bus.out_ready  = out_rdy;
    endtask

    task automatic push_expect(input logic [63:0] pc, input logic [31:0] instr);
        fetch_out_t e;
        e.pc    = pc;
        e.instr = instr;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < 40) begin
            tick();
            cyc++;
        end
        if (sb_q.size() != 0) begin
            checkOutput({name, "_timeout_pending"}, 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
    endtask

    task automatic wait_out_valid(input string name);
        int cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        if (!bus.out_valid) checkOutput({name, "_timeout_out_valid"}, 64'd0, 64'd1);
    endtask

    // Auto responder: answers each request accepted while enabled, one cycle after accept.
    initial begin
        logic [63:0] addr;
        auto_valid = 1'b0;
        auto_data  = '0;
        forever begin
            @(negedge clk);
            if (resp_en && resetn && bus.ireq_valid && bus.ireq_ready) begin
                addr = bus.ireq_addr;
                @(posedge clk);
                #1;
                auto_valid = 1'b1;
                auto_data  = instr_of(addr);
                @(posedge clk);
                #1;
                auto_valid = 1'b0;
            end
        end
    end

    // A handshake in a redirect cycle is a flush, not a delivery.
    always @(negedge clk) begin
        if (resetn && bus.out_valid && bus.out_ready && redir_valid == 2'b00) begin
            n_compared++;
            if (sb_q.size() == 0) begin
                n_mismatch++;
                $display("[TB] FAIL unexpected_out: got pc=%0h instr=%0h, expected none",
                         bus.out_pc, bus.out_instr);
            end else begin
                fetch_out_t e;
                e = sb_q.pop_front();
                if (bus.out_pc !== e.pc || bus.out_instr !== e.instr) begin
                    n_mismatch++;
                    $display("[TB] FAIL out_handshake: got pc=%0h instr=%0h, expected pc=%0h instr=%0h",
                             bus.out_pc, bus.out_instr, e.pc, e.instr);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        resp_en   = 1'b0;
        man_valid = 1'b0;
        man_data  = '0;
        applyStimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_out_pc", bus.out_pc, 64'd0);
        checkOutput("rst_out_instr", 64'(bus.out_instr), 64'd0);

        $display("[TB] test 1: sequential fetch");
        push_expect(64'h8000_0000, 32'h9357_0000);
        push_expect(64'h8000_0004, 32'h9357_0004);
        push_expect(64'h8000_0008, 32'h9357_0008);
        resp_en = 1'b1;
        applyStimulus(2'b00, 64'h0, 64'h0, 1'b1, 1'b1);
        resetn = 1'b1;
        #1;
        checkOutput("t1_first_ireq_valid", 64'(bus.ireq_valid), 64'd1);
        checkOutput("t1_first_ireq_addr", bus.ireq_addr, 64'h8000_0000);
        wait_drain("t1");
        bus.ireq_ready = 1'b0;
        checkOutput("t1_next_addr", bus.ireq_addr, 64'h8000_000C);

        $display("[TB] test 2: decode stall");
        push_expect(64'h8000_000C, 32'h9357_000C);
        applyStimulus(2'b00, 64'h0, 64'h0, 1'b1, 1'b0);
        tick();
        bus.ireq_ready = 1'b0;
        wait_out_valid("t2");
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_stall_out_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("t2_stall_out_pc", bus.out_pc, 64'h8000_000C);
            checkOutput("t2_stall_out_instr", 64'(bus.out_instr), 64'h9357_000C);
            checkOutput("t2_stall_ireq_valid", 64'(bus.ireq_valid), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        wait_drain("t2");

        $display("[TB] test 3: redirect priority in REQ");
        applyStimulus(2'b11, 64'h1000, 64'h2000, 1'b0, 1'b1);
        tick();
        redir_valid = 2'b00;
        checkOutput("t3_ireq_addr", bus.ireq_addr, 64'h1000);
        checkOutput("t3_ireq_valid", 64'(bus.ireq_valid), 64'd1);
        push_expect(64'h1000, 32'h1357_1000);
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        wait_drain("t3");
        checkOutput("t3_next_addr", bus.ireq_addr, 64'h1004);

        $display("[TB] test 4: redirect while waiting");
        resp_en = 1'b0;
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        applyStimulus(2'b10, 64'h0, 64'h3000, 1'b0, 1'b1);
        tick();
        redir_valid = 2'b00;
        checkOutput("t4_wait_ireq_valid", 64'(bus.ireq_valid), 64'd0);
        tick();
        man_valid = 1'b1;
        man_data  = 32'hDEAD_BEEF;
        tick();
        man_valid = 1'b0;
        checkOutput("t4_ireq_addr", bus.ireq_addr, 64'h3000);
        checkOutput("t4_ireq_valid", 64'(bus.ireq_valid), 64'd1);
        checkOutput("t4_out_valid", 64'(bus.out_valid), 64'd0);
        resp_en = 1'b1;
        push_expect(64'h3000, 32'h1357_3000);
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        wait_drain("t4");

        $display("[TB] test 4b: redirect on request accept");
        applyStimulus(2'b01, 64'h5000, 64'h0, 1'b1, 1'b1);
        tick();
        applyStimulus(2'b00, 64'h0, 64'h0, 1'b0, 1'b1);
        repeat (3) tick();
        checkOutput("t4b_ireq_addr", bus.ireq_addr, 64'h5000);
        checkOutput("t4b_out_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] test 5: alignment and flush in HOLD");
        applyStimulus(2'b01, 64'h4006, 64'h0, 1'b0, 1'b0);
        tick();
        redir_valid = 2'b00;
        checkOutput("t5_aligned_addr", bus.ireq_addr, 64'h4004);
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        wait_out_valid("t5");
        checkOutput("t5_hold_out_pc", bus.out_pc, 64'h4004);
        applyStimulus(2'b01, 64'h6000, 64'h0, 1'b0, 1'b1);
        tick();
        redir_valid = 2'b00;
        checkOutput("t5_flush_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t5_flush_ireq_addr", bus.ireq_addr, 64'h6000);

        $display("[TB] test 6: reset in WAIT");
        resp_en = 1'b0;
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        resetn = 1'b0;
        #1;
        checkOutput("t6_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("t6_out_pc", bus.out_pc, 64'd0);
        checkOutput("t6_ireq_valid", 64'(bus.ireq_valid), 64'd0);
        repeat (2) tick();
        resetn = 1'b1;
        #1;
        checkOutput("t6_ireq_addr", bus.ireq_addr, 64'h8000_0000);
        checkOutput("t6_ireq_valid_rel", 64'(bus.ireq_valid), 64'd1);
        resp_en = 1'b1;
        push_expect(64'h8000_0000, 32'h9357_0000);
        tick();
        bus.ireq_ready = 1'b1;
        tick();
        bus.ireq_ready = 1'b0;
        wait_drain("t6");

        repeat (3) tick();
        checkOutput("final_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
